keypad_scan_ctrl: RTL and testbench

Parametrised matrix-keypad scanner: drives one-hot row strobes and samples column inputs into a full-matrix snapshot. It debounces the whole matrix and emits per-key press/release events through a small FIFO with a valid/ready handshake. An optional auto-repeat mode re-emits the press event of a single held key. It replaces the fixed 4x4 single-code keypad front end and feeds the display/command logic.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_event_fifo.sv | 57 +++++
 rtl/keypad_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, event-code sizing and helpers for the keypad scanner
package keypad_pkg;

  localparam int DEF_ROWS       = 4;
  localparam int DEF_COLS       = 4;
  localparam int DEF_SCAN_DIV   = 50000;
  localparam int DEF_DEBOUNCE   = 3;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_RPT_DELAY  = 20;
  localparam int DEF_RPT_RATE   = 5;

  // Widest matrix the popcount helper accepts.
  localparam int MAX_KEYS = 64;

  typedef enum logic {
    EM_IDLE,
    EM_WALK
  } emit_state_t;

  function automatic int ev_w(input int rows, input int cols);
    return 1 + $clog2(rows * cols);
  endfunction

  function automatic int rel_bit(input int rows, input int cols);
    return ev_w(rows, cols) - 1;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_KEYS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_KEYS; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// rtl/keypad_event_fifo.sv - first-word-fall-through event queue with drop-on-full and sticky overflow
module keypad_event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tvalid,
  output logic [WIDTH-1:0] out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, pop, push_ok, drop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = out_tvalid & out_tready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push_ok = in_tvalid & (~full | pop);
  assign drop    = in_tvalid & full & ~pop;

  assign out_tvalid = ~empty;
  assign out_tdata  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= in_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - matrix keypad scanner with full-matrix debounce, press/release events and auto-repeat
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int DEBOUNCE   = DEF_DEBOUNCE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_RATE   = DEF_RPT_RATE,
  localparam int EV_W      = ev_w(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_select,
  input  logic            rpt_en,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [EV_W-1:0] ev_code,
  output logic            pressed,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int NK  = ROWS * COLS;
  localparam int KW  = EV_W - 1;
  localparam int REL = rel_bit(ROWS, COLS);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int NW  = $clog2(DEBOUNCE + 1);
  localparam int RPW = $clog2(((RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE) + 1);

  logic [DW-1:0]   dwell;
  logic [RW-1:0]   row_idx;
  logic [NK-1:0]   snap, snap_full, cand, cand_next, m_stable, m_old;
  logic [NW-1:0]   n_cnt, n_next;
  logic            sample, snap_done, accept;
  emit_state_t     em_state, em_next;
  logic [KW-1:0]   emit_idx, held_idx;
  logic            emit_push;
  logic [RPW-1:0]  rpt_cnt, rpt_inc;
  logic            rpt_started, rpt_pend, rpt_ok, rpt_fire;
  logic            push;
  logic [EV_W-1:0] push_code;

  assign sample    = (dwell == DW'(SCAN_DIV - 1));
  assign snap_done = sample & (row_idx == RW'(ROWS - 1));
  assign pressed   = |m_stable;

  // Snapshot as it will look once the current row is latched.
  always_comb begin
    snap_full = snap;
    snap_full[row_idx*COLS +: COLS] = col_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell      <= '0;
      row_idx    <= '0;
      row_select <= ROWS'(1);
      snap       <= '0;
    end else if (sample) begin
      dwell      <= '0;
      snap       <= snap_full;
      row_select <= {row_select[ROWS-2:0], row_select[ROWS-1]};
      row_idx    <= snap_done ? '0 : row_idx + RW'(1);
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  always_comb begin
    accept    = 1'b0;
    n_next    = n_cnt;
    cand_next = cand;
    if (snap_done) begin
      if (snap_full == m_stable) begin
        n_next = '0;
      end else begin
        if (snap_full == cand) begin
          n_next = n_cnt + NW'(1);
        end else begin
          cand_next = snap_full;
          n_next    = NW'(1);
        end
        if (n_next == NW'(DEBOUNCE)) begin
          accept = 1'b1;
          n_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cand     <= '0;
      n_cnt    <= '0;
      m_stable <= '0;
      m_old    <= '0;
    end else begin
      cand  <= cand_next;
      n_cnt <= n_next;
      if (accept) begin
        m_old    <= m_stable;
        m_stable <= snap_full;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      em_state <= EM_IDLE;
      emit_idx <= '0;
    end else begin
      em_state <= em_next;
      emit_idx <= (em_state == EM_WALK) ? emit_idx + KW'(1) : '0;
    end
  end

  always_comb begin
    em_next = em_state;
    case (em_state)
      EM_IDLE: if (accept) em_next = EM_WALK;
      EM_WALK: if (emit_idx == KW'(NK - 1)) em_next = EM_IDLE;
      default: em_next = EM_IDLE;
    endcase
  end

  assign emit_push = (em_state == EM_WALK) && (m_old[emit_idx] != m_stable[emit_idx]);

  always_comb begin
    held_idx = '0;
    for (int i = 0; i < NK; i++) if (m_stable[i]) held_idx = KW'(i);
  end

  assign rpt_ok  = rpt_en && (popcount(MAX_KEYS'(m_stable)) == 1);
  assign rpt_inc = rpt_cnt + RPW'(1);

  always_comb begin
    rpt_fire = 1'b0;
    if (snap_done && !accept && rpt_ok)
      rpt_fire = rpt_started ? (rpt_inc == RPW'(RPT_RATE)) : (rpt_inc == RPW'(RPT_DELAY));
  end

  // The repeat is pushed one clock after the scan boundary; the emitter is idle by then.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_cnt     <= '0;
      rpt_started <= 1'b0;
      rpt_pend    <= 1'b0;
    end else begin
      rpt_pend <= rpt_fire;
      if (accept || !rpt_ok) begin
        rpt_cnt     <= '0;
        rpt_started <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt     <= '0;
        rpt_started <= 1'b1;
      end else if (snap_done) begin
        rpt_cnt <= rpt_inc;
      end
    end
  end

  assign push = emit_push | rpt_pend;

  always_comb begin
    push_code             = '0;
    push_code[KW-1:0]     = rpt_pend ? held_idx : emit_idx;
    push_code[REL]        = !rpt_pend && m_old[emit_idx];
  end

  keypad_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_tdata   (push_code),
    .in_tvalid  (push),
    .out_tdata  (ev_code),
    .out_tvalid (ev_valid),
    .out_tready (ev_ready),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - scoreboard bench for keypad_scan_ctrl with a small key-matrix model
module tb_keypad_scan_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row_select;
  logic        rpt_en;
  logic        ev_valid;
  logic        ev_ready;
  logic [4:0]  ev_code;
  logic        pressed;
  logic        ovf;
  logic        ovf_clr;
  logic [15:0] keys;

  logic [4:0]  exp_q[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .SCAN_DIV   (4),
    .DEBOUNCE   (2),
    .FIFO_DEPTH (4),
    .RPT_DELAY  (3),
    .RPT_RATE   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_in     (col_in),
    .row_select (row_select),
    .rpt_en     (rpt_en),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .pressed    (pressed),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  // Physical matrix: a held key shorts its row strobe onto its column.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < ROWS; r++)
      if (row_select[r]) col_in = col_in | keys[r*COLS +: COLS];
  end

  always @(negedge clk) begin
    if (rst && ev_valid && ev_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event actual=%h required=none", ev_code);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if (ev_code !== e) begin
          bad++;
          $display("FAIL event_code actual=%h required=%h", ev_code, e);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves time just after the edge that returns the strobe to row 0.
  task automatic align_scan();
    bit seen_last;
    seen_last = 1'b0;
    for (int g = 0; g < 80; g++) begin
      tick(1);
      if (row_select == 4'b1000) seen_last = 1'b1;
      else if (seen_last && row_select == 4'b0001) return;
    end
    check("align_timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b0; keys = '0; rpt_en = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    check("rst_row_select", row_select, 4'b0001);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_code", ev_code, 0);
    check("rst_pressed", pressed, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b1;
    for (int k = 0; k < 32; k++) begin
      check("row_seq", row_select, 1 << ((k / 4) % 4));
      tick(1);
    end
    check("idle_ev_valid", ev_valid, 0);
    check("idle_pressed", pressed, 0);

    ev_ready = 1'b1;
    align_scan();
    exp_q.push_back(5'h0A);
    keys[10] = 1'b1;
    tick(48);
    check("single_press_pressed", pressed, 1);
    check("single_press_drained", exp_q.size(), 0);
    exp_q.push_back(5'h1A);
    keys[10] = 1'b0;
    tick(48);
    check("single_release_pressed", pressed, 0);
    check("single_release_drained", exp_q.size(), 0);

    align_scan();
    keys[10] = 1'b1;
    tick(16);
    keys[10] = 1'b0;
    tick(48);
    check("glitch_pressed", pressed, 0);
    check("glitch_ev_valid", ev_valid, 0);

    align_scan();
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h0C);
    keys[3] = 1'b1; keys[12] = 1'b1;
    tick(48);
    check("multi_press_drained", exp_q.size(), 0);
    check("multi_press_pressed", pressed, 1);
    exp_q.push_back(5'h13);
    exp_q.push_back(5'h1C);
    keys = '0;
    tick(48);
    check("multi_release_drained", exp_q.size(), 0);

    ev_ready = 1'b0;
    align_scan();
    keys[4:0] = 5'h1F;
    tick(48);
    check("bp_ovf_set", ovf, 1);
    check("bp_ev_valid", ev_valid, 1);
    check("bp_head", ev_code, 5'h00);
    tick(5);
    check("bp_head_stable", ev_code, 5'h00);
    for (int i = 0; i < 4; i++) exp_q.push_back(5'(i));
    ev_ready = 1'b1;
    tick(8);
    check("bp_drained", exp_q.size(), 0);
    check("bp_empty_after_drain", ev_valid, 0);
    check("bp_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("bp_ovf_clr", ovf, 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(5'h10 + 5'(i));
    keys = '0;
    tick(48);
    check("bp_release_drained", exp_q.size(), 0);
    check("bp_release_no_ovf", ovf, 0);
    check("bp_release_pressed", pressed, 0);

    rpt_en = 1'b1;
    align_scan();
    for (int i = 0; i < 4; i++) exp_q.push_back(5'h05);
    keys[5] = 1'b1;
    tick(72);
    check("rpt_before_first", exp_q.size(), 3);
    tick(16);
    check("rpt_after_scan3", exp_q.size(), 2);
    tick(16);
    check("rpt_gap_scan4", exp_q.size(), 2);
    tick(16);
    check("rpt_after_scan5", exp_q.size(), 1);
    tick(16);
    check("rpt_gap_scan6", exp_q.size(), 1);
    tick(16);
    check("rpt_after_scan7", exp_q.size(), 0);
    exp_q.push_back(5'h05);
    exp_q.push_back(5'h06);
    keys[6] = 1'b1;
    tick(56);
    check("rpt_second_key_drained", exp_q.size(), 0);
    tick(96);
    check("rpt_two_keys_quiet", exp_q.size(), 0);
    rpt_en = 1'b0;
    exp_q.push_back(5'h16);
    keys[6] = 1'b0;
    tick(128);
    check("rpt_disabled_drained", exp_q.size(), 0);
    check("rpt_disabled_pressed", pressed, 1);
    exp_q.push_back(5'h15);
    keys[5] = 1'b0;
    tick(48);
    check("rpt_final_release", exp_q.size(), 0);
    check("rpt_final_pressed", pressed, 0);

    ev_ready = 1'b0;
    keys[0] = 1'b1;
    tick(48);
    check("midrst_pending", ev_valid, 1);
    rst = 1'b0;
    tick(1);
    check("midrst_ev_valid", ev_valid, 0);
    check("midrst_pressed", pressed, 0);
    check("midrst_row_select", row_select, 4'b0001);
    rst = 1'b1;
    keys = '0;
    tick(4);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
